// File: rtl/activity_traffic_gen_if.sv
// Flit stream from the traffic generator to the operand inputs of the block
// under characterization. The master drives a 2N-bit word split into two operands.
interface activity_traffic_gen_if #(
    parameter int unsigned N = 27
);
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;

    modport master (
        output out_valid,
        output out_last,
        output operand_a,
        output operand_b,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_last,
        input  operand_a,
        input  operand_b,
        output out_ready
    );
endinterface

// File: rtl/activity_traffic_gen.sv
// Programmable packetised operand generator for switching-activity characterization.
// Emits packets of 2N-bit words with a selectable toggle pattern and idle gaps,
// and counts accepted flits and toggled operand bits across the whole run.
module activity_traffic_gen #(
    parameter int unsigned N     = 27,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             cfg_mode,
    input  logic [2*N-1:0]         cfg_seed,
    input  logic [2*N-1:0]         cfg_mask,
    input  logic [LEN_W-1:0]       cfg_payload,
    input  logic [LEN_W-1:0]       cfg_gap,
    input  logic [LEN_W-1:0]       cfg_npkt,
    activity_traffic_gen_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       flit_count,
    output logic [CNT_W-1:0]       toggle_count
);
    localparam int unsigned W    = 2 * N;
    localparam int unsigned PopW = $clog2(W + 1);
    localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e           state_q;
    logic [1:0]       mode_q;
    logic [W-1:0]     seed_q;
    logic [W-1:0]     mask_q;
    logic [W-1:0]     word_q;
    logic [W-1:0]     prev_q;
    logic [LEN_W-1:0] last_beat_q;
    logic [LEN_W-1:0] last_pkt_q;
    logic [LEN_W-1:0] gap_q;
    logic [LEN_W-1:0] beat_idx_q;
    logic [LEN_W-1:0] pkt_idx_q;
    logic [LEN_W-1:0] gap_cnt_q;

    logic [W-1:0]     seed_eff;
    logic [W-1:0]     word_next;
    logic [W-1:0]     diff;
    logic [PopW-1:0]  pop;
    logic [SumW-1:0]  tog_sum;
    logic             accept;
    logic             beat_last;

    // An all-zero LFSR would lock up, so mode 2 substitutes 1 for a zero seed.
    assign seed_eff = (cfg_mode == 2'd2 && cfg_seed == '0) ? W'(1) : cfg_seed;

    assign accept        = (state_q == StSend) && bus.out_ready;
    assign beat_last     = (beat_idx_q == last_beat_q);
    assign bus.out_valid = (state_q == StSend);
    assign bus.out_last  = (state_q == StSend) && beat_last;
    assign bus.operand_a = word_q[N-1:0];
    assign bus.operand_b = word_q[W-1:N];
    assign busy          = (state_q == StSend) || (state_q == StGap);
    assign done          = (state_q == StDone);

    // Pattern step applied after each accepted non-last flit.
    always_comb begin
        word_next = word_q;
        case (mode_q)
            2'd0:    word_next = word_q;
            2'd1:    word_next = word_q ^ mask_q;
            2'd2:    word_next = {word_q[W-2:0], word_q[W-1] ^ word_q[W-3] ^ word_q[0]};
            default: word_next = word_q + W'(1);
        endcase
    end

    // Bits that toggle on the operand bus when the current word is accepted.
    always_comb begin
        diff = word_q ^ prev_q;
        pop  = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + PopW'(diff[i]);
        end
        tog_sum = SumW'(toggle_count) + SumW'(pop);
    end

    // Run sequencer: config latch, packet/beat tracking, gap timing and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= '0;
            seed_q       <= '0;
            mask_q       <= '0;
            word_q       <= '0;
            prev_q       <= '0;
            last_beat_q  <= '0;
            last_pkt_q   <= '0;
            gap_q        <= '0;
            beat_idx_q   <= '0;
            pkt_idx_q    <= '0;
            gap_cnt_q    <= '0;
            flit_count   <= '0;
            toggle_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q       <= cfg_mode;
                        seed_q       <= seed_eff;
                        mask_q       <= cfg_mask;
                        last_beat_q  <= (cfg_payload == '0) ? '0 : cfg_payload - LEN_W'(1);
                        last_pkt_q   <= cfg_npkt - LEN_W'(1);
                        gap_q        <= cfg_gap;
                        word_q       <= seed_eff;
                        prev_q       <= '0;
                        beat_idx_q   <= '0;
                        pkt_idx_q    <= '0;
                        flit_count   <= '0;
                        toggle_count <= '0;
                        state_q      <= (cfg_npkt == '0) ? StDone : StSend;
                    end
                end
                StSend: begin
                    if (accept) begin
                        flit_count   <= (&flit_count) ? flit_count : flit_count + CNT_W'(1);
                        toggle_count <= (tog_sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                                         : tog_sum[CNT_W-1:0];
                        // prev_q survives packet boundaries to track real bus activity.
                        prev_q       <= word_q;
                        if (beat_last) begin
                            beat_idx_q <= '0;
                            word_q     <= seed_q;
                            if (pkt_idx_q == last_pkt_q) begin
                                state_q <= StDone;
                            end else begin
                                pkt_idx_q <= pkt_idx_q + LEN_W'(1);
                                if (gap_q != '0) begin
                                    gap_cnt_q <= gap_q;
                                    state_q   <= StGap;
                                end
                            end
                        end else begin
                            beat_idx_q <= beat_idx_q + LEN_W'(1);
                            word_q     <= word_next;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == LEN_W'(1)) begin
                        state_q <= StSend;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - LEN_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_activity_traffic_gen.sv
// Randomized bench for activity_traffic_gen (N=4). A queue-based packet model
// predicts every flit, packet boundary, gap length and final statistic.
module tb_activity_traffic_gen;
    localparam int unsigned N = 4;
    localparam int unsigned W = 2 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [1:0]   cfg_mode;
    logic [W-1:0] cfg_seed;
    logic [W-1:0] cfg_mask;
    logic [15:0]  cfg_payload;
    logic [15:0]  cfg_gap;
    logic [15:0]  cfg_npkt;
    logic         busy;
    logic         done;
    logic [31:0]  flit_count;
    logic [31:0]  toggle_count;
    logic         busy_s;
    logic         done_s;
    logic [3:0]   flit_s;
    logic [3:0]   tog_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    activity_traffic_gen_if #(.N(N)) bus ();
    activity_traffic_gen_if #(.N(N)) bus_s ();

    assign bus.out_ready   = ready;
    assign bus_s.out_ready = ready;

    activity_traffic_gen #(.N(N), .LEN_W(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_mode     (cfg_mode),
        .cfg_seed     (cfg_seed),
        .cfg_mask     (cfg_mask),
        .cfg_payload  (cfg_payload),
        .cfg_gap      (cfg_gap),
        .cfg_npkt     (cfg_npkt),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .flit_count   (flit_count),
        .toggle_count (toggle_count)
    );

    // Narrow-counter instance, used only for saturation checks.
    activity_traffic_gen #(.N(N), .LEN_W(16), .CNT_W(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_mode     (cfg_mode),
        .cfg_seed     (cfg_seed),
        .cfg_mask     (cfg_mask),
        .cfg_payload  (cfg_payload),
        .cfg_gap      (cfg_gap),
        .cfg_npkt     (cfg_npkt),
        .bus          (bus_s),
        .busy         (busy_s),
        .done         (done_s),
        .flit_count   (flit_s),
        .toggle_count (tog_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pattern rules stated arithmetically on an 8-bit word.
    function automatic logic [W-1:0] model_next(input logic [1:0] m, input logic [W-1:0] w,
                                                input logic [W-1:0] mask);
        int v;
        int fb;
        v = int'(w);
        case (m)
            2'd0:    return w;
            2'd1:    return w ^ mask;
            2'd2: begin
                fb = ((v >> 7) ^ (v >> 5) ^ v) & 1;
                return W'(((v * 2) % 256) + fb);
            end
            default: return W'((v + 1) % 256);
        endcase
    endfunction

    task automatic run_case(input logic [1:0] m, input logic [W-1:0] seed, input logic [W-1:0] mask,
                            input int payload, input int gap, input int npkt, input int rmode);
        logic [W-1:0] exp_w[$];
        bit           exp_l[$];
        logic [W-1:0] w;
        logic [W-1:0] s;
        logic [W-1:0] prev;
        logic [W-1:0] held_w;
        int           plen, flits, tog, budget, last_acc, gap_run;
        bit           in_gap, held, finished;

        plen = (payload == 0) ? 1 : payload;
        s    = (m == 2'd2 && seed == '0) ? W'(1) : seed;
        prev = '0;
        tog  = 0;
        for (int p = 0; p < npkt; p++) begin
            w = s;
            for (int b = 0; b < plen; b++) begin
                exp_w.push_back(w);
                exp_l.push_back(b == plen - 1);
                tog += $countones(w ^ prev);
                prev = w;
                w = model_next(m, w, mask);
            end
        end
        flits  = npkt * plen;
        budget = (plen + gap) * npkt * 4 + 10;

        @(negedge clk);
        cfg_mode    = m;
        cfg_seed    = seed;
        cfg_mask    = mask;
        cfg_payload = 16'(payload);
        cfg_gap     = 16'(gap);
        cfg_npkt    = 16'(npkt);
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        last_acc = 0;
        gap_run  = 0;
        in_gap   = 1'b0;
        held     = 1'b0;
        finished = 1'b0;
        held_w   = '0;

        for (int c = 1; c <= budget; c++) begin
            if (done) begin
                check_eq("done_cycle", 64'(c), 64'(npkt == 0 ? 1 : last_acc + 1));
                check_eq("leftover_flits", 64'(exp_w.size()), 64'(0));
                check_eq("flit_count", 64'(flit_count), 64'(flits));
                check_eq("toggle_count", 64'(toggle_count), 64'(tog));
                check_eq("flit_count_sat", 64'(flit_s), 64'(flits > 15 ? 15 : flits));
                check_eq("toggle_count_sat", 64'(tog_s), 64'(tog > 15 ? 15 : tog));
                check_eq("busy_in_done", 64'(busy), 64'(0));
                finished = 1'b1;
                break;
            end
            check_eq("busy", 64'(busy), 64'(1));
            if (c == 1 && npkt > 0) check_eq("first_valid", 64'(bus.out_valid), 64'(1));
            if (held) begin
                check_eq("stall_hold", 64'({bus.out_valid, bus.operand_b, bus.operand_a}),
                         64'({1'b1, held_w}));
            end
            held = 1'b0;
            if (bus.out_valid) begin
                if (in_gap) begin
                    check_eq("gap_len", 64'(gap_run), 64'(gap));
                    in_gap = 1'b0;
                end
                if (exp_w.size() == 0) begin
                    check_eq("extra_flit", 64'(bus.out_valid), 64'(0));
                end else begin
                    check_eq("word", 64'({bus.operand_b, bus.operand_a}), 64'(exp_w[0]));
                    check_eq("last", 64'(bus.out_last), 64'(exp_l[0]));
                end
            end else if (in_gap) begin
                gap_run++;
            end

            // Drive the next cycle: sink readiness, stray start, scrambled config.
            if (rmode == 0)      ready = 1'b1;
            else if (rmode == 1) ready = (c % 2 == 1);
            else                 ready = ($urandom_range(3) != 0);
            start       = (c == 2);
            cfg_mode    = 2'($urandom);
            cfg_seed    = W'($urandom);
            cfg_mask    = W'($urandom);
            cfg_payload = 16'($urandom_range(7));
            cfg_gap     = 16'($urandom_range(7));
            cfg_npkt    = 16'($urandom_range(7));

            if (bus.out_valid && exp_w.size() > 0) begin
                if (ready) begin
                    last_acc = c;
                    if (exp_l[0] && exp_w.size() > 1) begin
                        in_gap  = 1'b1;
                        gap_run = 0;
                    end
                    void'(exp_w.pop_front());
                    void'(exp_l.pop_front());
                end else begin
                    held   = 1'b1;
                    held_w = {bus.operand_b, bus.operand_a};
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) begin
            check_eq("done_timeout", 64'(done), 64'(1));
        end else begin
            @(negedge clk);
            check_eq("idle_after_done", 64'({done, busy, bus.out_valid}), 64'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bus"}, 64'({bus.out_valid, bus.out_last, bus.operand_b, bus.operand_a}),
                 64'(0));
        check_eq({tag, "_status"}, 64'({busy, done, busy_s, done_s}), 64'(0));
        check_eq({tag, "_flit_count"}, 64'(flit_count), 64'(0));
        check_eq({tag, "_toggle_count"}, 64'(toggle_count), 64'(0));
        check_eq({tag, "_sat_counts"}, 64'({flit_s, tog_s}), 64'(0));
    endtask

    task automatic reset_mid_gap();
        @(negedge clk);
        cfg_mode    = 2'd3;
        cfg_seed    = 8'h10;
        cfg_mask    = '0;
        cfg_payload = 16'd2;
        cfg_gap     = 16'd4;
        cfg_npkt    = 16'd2;
        ready       = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("in_gap_before_rst", 64'({busy, bus.out_valid}), 64'(2'b10));
        check_eq("count_before_rst", 64'(flit_count), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_gap_rst");
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        ready       = 1'b0;
        cfg_mode    = '0;
        cfg_seed    = '0;
        cfg_mask    = '0;
        cfg_payload = '0;
        cfg_gap     = '0;
        cfg_npkt    = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_case(2'd1, 8'h00, 8'hFF, 4, 2, 2, 0);
        run_case(2'd1, 8'h00, 8'hFF, 4, 2, 2, 1);
        run_case(2'd2, 8'h00, 8'h00, 3, 0, 2, 0);
        run_case(2'd1, 8'h5A, 8'h33, 3, 1, 0, 0);
        run_case(2'd3, 8'h07, 8'h00, 0, 1, 3, 2);
        run_case(2'd3, 8'hFF, 8'h00, 2, 0, 1, 0);
        run_case(2'd1, 8'h00, 8'hFF, 8, 0, 1, 0);
        reset_mid_gap();
        run_case(2'd1, 8'h00, 8'hFF, 4, 2, 2, 0);
        for (int i = 0; i < 24; i++) begin
            run_case(2'($urandom_range(3)), W'($urandom), W'($urandom),
                     int'($urandom_range(5)), int'($urandom_range(3)),
                     int'($urandom_range(3)), int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
